// File: rtl/uart_tx_mmio_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_mmio_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - FSM state encodings (legacy-compatible localparam constants)
//   - register offsets decoded from the word address [1:0]
//   - STATUS bit positions and the DIVISOR parity-select bit position
//   - parity helper function
// Optional feature macro: UART_TX_PARITY_EN (PARITY state, odd/even select).
// -----------------------------------------------------------------------------
package uart_tx_mmio_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_OVERRUN_BIT = 1;
    localparam int DIV_ODD_BIT        = 16;

    // Even parity of a byte: 1 when the byte holds an odd number of ones.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Down-counter that measures one bit period. A reload strobe loads
// (divisor - 1); the counter then decrements once per clock and holds at 0.
// tick is high while the count is 0, i.e. in the last clock of the period,
// so a period lasts exactly load_val + 1 clocks.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   load     in  reload strobe (start of a bit period on the next edge)
//   load_val in  value to load (clocks per bit minus one)
//   tick     out last clock of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload, decrement, or hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/uart_tx_mmio.sv
// -----------------------------------------------------------------------------
// uart_tx_mmio
// Memory-mapped 8N1 UART transmitter (LSB first) with programmable divisor.
// Register map (in_address[1:0]):
//   0 TXDATA  : write [7:0] starts a frame when idle; reads last byte written
//   1 STATUS  : reads {overrun, busy}; any write clears overrun
//   2 DIVISOR : clocks per bit, values below 2 stored as 2
//   3         : reads 0, writes ignored
// Ports:
//   clk, rst (async active-high), in_write_en, in_address[31:0], in_data[31:0]
//   out_read_data[31:0] (combinational from in_address), out_tx, out_busy
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit between data
// and stop; DIVISOR bit 16 selects odd parity when set.
// -----------------------------------------------------------------------------
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int                DIV_W     = 16,
    parameter logic [DIV_W-1:0] DIV_RESET = 16'd5208
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_write_en,
    input  logic [31:0] in_address,
    input  logic [31:0] in_data,
    output logic [31:0] out_read_data,
    output logic        out_tx,
    output logic        out_busy
);

    localparam logic [DIV_W-1:0] DIV_MIN = {{(DIV_W-2){1'b0}}, 2'b10};
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q,   state_d;
    logic [7:0]       shift_q,   shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             tx_q,      tx_d;
    logic             busy_q,    busy_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       txdata_q,  txdata_d;
    logic [DIV_W-1:0] div_q,     div_d;
`ifdef UART_TX_PARITY_EN
    logic             odd_q,     odd_d;
    logic             par_q,     par_d;
`endif

    logic             wr_txdata_s;
    logic             start_s;
    logic             tick_s;
    logic             load_s;
    logic [DIV_W-1:0] load_val_s;
    logic [DIV_W-1:0] new_div_s;
    logic             unused_s;

    assign wr_txdata_s = in_write_en && (in_address[1:0] == REG_TXDATA);
    // A write is accepted only from IDLE; the STOP->IDLE cycle still counts as busy.
    assign start_s     = wr_txdata_s && (state_q == IDLE);
    // Reload on frame start and at the end of every bit; the divisor sampled
    // here is what the next bit uses, so mid-frame writes never disturb a bit.
    assign load_s      = start_s || ((state_q != IDLE) && tick_s);
    assign load_val_s  = div_q - DIV_ONE;
    assign new_div_s   = (in_data[DIV_W-1:0] < DIV_MIN) ? DIV_MIN : in_data[DIV_W-1:0];
    assign unused_s    = ^{in_address[31:2], in_data[31:DIV_W]};

    uart_baud_counter #(.W(DIV_W)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .tick     (tick_s)
    );

    // Register-file next state: TXDATA, DIVISOR, overrun flag.
    always_comb begin
        txdata_d  = txdata_q;
        div_d     = div_q;
        overrun_d = overrun_q;
`ifdef UART_TX_PARITY_EN
        odd_d     = odd_q;
`endif
        if (in_write_en) begin
            case (in_address[1:0])
                REG_TXDATA: begin
                    txdata_d = in_data[7:0];
                    if (state_q != IDLE) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
                REG_STATUS: begin
                    overrun_d = 1'b0;
                end
                REG_DIVISOR: begin
                    div_d = new_div_s;
`ifdef UART_TX_PARITY_EN
                    odd_d = in_data[DIV_ODD_BIT];
`endif
                end
                default: begin
                    txdata_d = txdata_q;
                end
            endcase
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Transmit FSM next state: line level, shift register and bit index.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d   = START;
                    shift_d   = in_data[7:0];
                    bit_idx_d = 3'd0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d     = even_parity(in_data[7:0]) ^ odd_q;
`endif
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            START: begin
                if (tick_s) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        tx_d      = par_q;
`else
                        state_d   = STOP;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    state_d = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick_s) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            STOP: begin
                if (tick_s) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_idx_d = 3'd0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and register flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            txdata_q  <= 8'h00;
            div_q     <= DIV_RESET;
`ifdef UART_TX_PARITY_EN
            odd_q     <= 1'b0;
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            txdata_q  <= txdata_d;
            div_q     <= div_d;
`ifdef UART_TX_PARITY_EN
            odd_q     <= odd_d;
            par_q     <= par_d;
`endif
        end
    end

    // Read mux, combinational from the address; reads have no side effects.
    always_comb begin
        out_read_data = 32'h0000_0000;
        case (in_address[1:0])
            REG_TXDATA: begin
                out_read_data[7:0] = txdata_q;
            end
            REG_STATUS: begin
                out_read_data[STATUS_BUSY_BIT]    = busy_q;
                out_read_data[STATUS_OVERRUN_BIT] = overrun_q;
            end
            REG_DIVISOR: begin
                out_read_data[DIV_W-1:0] = div_q;
`ifdef UART_TX_PARITY_EN
                out_read_data[DIV_ODD_BIT] = odd_q;
`endif
            end
            default: begin
                out_read_data = 32'h0000_0000;
            end
        endcase
    end

    assign out_tx   = tx_q;
    assign out_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_mmio
// Self-checking bench for uart_tx_mmio: register table, frame reference model
// built from bit lists, overrun / end-of-frame collision, divisor clamping,
// mid-frame reset and randomized frames. Honours UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_tx_mmio;

    logic        clk;
    logic        rst;
    logic        in_write_en;
    logic [31:0] in_address;
    logic [31:0] in_data;
    logic [31:0] out_read_data;
    logic        out_tx;
    logic        out_busy;

    int total = 0;
    int bad   = 0;

    uart_tx_mmio dut (
        .clk           (clk),
        .rst           (rst),
        .in_write_en   (in_write_en),
        .in_address    (in_address),
        .in_data       (in_data),
        .out_read_data (out_read_data),
        .out_tx        (out_tx),
        .out_busy      (out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        in_write_en = 1'b1;
        in_address  = {30'd0, a};
        in_data     = d;
        @(negedge clk);
        in_write_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        in_address = {30'd0, a};
        #1;
        v = out_read_data;
    endtask

    // Starts a frame of byte b at divisor dv and compares the line against a
    // clock-by-clock list built from the frame rules. Optionally injects a
    // TXDATA write after sample inj. Returns STATUS as read on the last busy clock.
    task automatic send_frame(input logic [7:0] b, input int dv, input logic odd,
                              input int inj, input logic [7:0] inj_b,
                              output logic [31:0] st_last);
        int bits[$];
        int expq[$];
        int errs;
        int busy_cnt;
        int n;
        bits.push_back(0);
        for (int k = 0; k < 8; k++) bits.push_back((b >> k) & 1);
`ifdef UART_TX_PARITY_EN
        bits.push_back((($countones(b) % 2) ^ int'(odd)) & 1);
`else
        if (odd) bits.push_back(1);   // odd only matters with parity; keep stop bit below
        if (odd) void'(bits.pop_back());
`endif
        bits.push_back(1);
        foreach (bits[k]) for (int r = 0; r < dv; r++) expq.push_back(bits[k]);
        n = expq.size();
        errs = 0;
        busy_cnt = 0;
        st_last = 32'hFFFF_FFFF;
        @(negedge clk);
        in_write_en = 1'b1;
        in_address  = 32'd0;
        in_data     = {24'd0, b};
        @(posedge clk); #1;
        in_write_en = 1'b0;
        in_address  = 32'd1;
        for (int i = 0; i < n; i++) begin
            if (out_tx !== expq[i][0]) errs++;
            if (out_busy === 1'b1) busy_cnt++;
            if (i == n - 1) st_last = out_read_data;
            if (i == inj) begin
                in_write_en = 1'b1;
                in_address  = 32'd0;
                in_data     = {24'd0, inj_b};
            end
            @(posedge clk); #1;
            in_write_en = 1'b0;
            in_address  = 32'd1;
        end
        chk("frame_bits_errs", errs, 0);
        chk("frame_busy_clocks", busy_cnt, n);
        chk("frame_end_line_busy", {30'd0, out_tx, out_busy}, 32'h2);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] v;
    logic [31:0] st;
    logic [31:0] div_hi_exp;
    int          cnt;

    initial begin
`ifdef UART_TX_PARITY_EN
        div_hi_exp = 32'h0001_ABCD;
`else
        div_hi_exp = 32'h0000_ABCD;
`endif
        vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 2'd1, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, 2'd2, 32'h0,         32'h1458};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, 2'd2, 32'h0,         32'h2};
        vecs[5]  = '{1'b1, 2'd2, 32'h1,         32'h2};
        vecs[6]  = '{1'b1, 2'd2, 32'h7,         32'h7};
        vecs[7]  = '{1'b1, 2'd2, 32'hFFFF,      32'hFFFF};
        vecs[8]  = '{1'b1, 2'd2, 32'h0001_ABCD, div_hi_exp};
        vecs[9]  = '{1'b1, 2'd3, 32'hDEAD_BEEF, 32'h0};
        vecs[10] = '{1'b1, 2'd1, 32'hFF,        32'h0};
        vecs[11] = '{1'b1, 2'd2, 32'h4,         32'h4};

        rst = 1'b1;
        in_write_en = 1'b0;
        in_address = 32'd0;
        in_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", {31'd0, out_tx}, 32'h1);
        chk("reset_busy", {31'd0, out_busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Register table.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, v);
            chk($sformatf("reg_vec%0d", i), v, vecs[i].exp);
        end

        // 0x55 at divisor 4: alternating line, 40 busy clocks.
        wr(2'd2, 32'd4);
        send_frame(8'h55, 4, 1'b0, -1, 8'h00, st);
        chk("x55_status_mid", st, 32'h1);

        // Overrun: second byte dropped mid-frame; STATUS 3 during, 2 after, 0 after clear.
        send_frame(8'hA3, 4, 1'b0, 9, 8'h41, st);
        chk("ovr_status_mid", st, 32'h3);
        rd(2'd1, v);
        chk("ovr_status_after", v, 32'h2);
        wr(2'd1, 32'h0);
        rd(2'd1, v);
        chk("ovr_status_cleared", v, 32'h0);

        // Write on the STOP->IDLE cycle is dropped and flags overrun.
        send_frame(8'h3C, 4, 1'b0, 39, 8'h99, st);
        chk("edge_status_last", st, 32'h1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_busy !== 1'b0 || out_tx !== 1'b1) cnt++;
        end
        chk("edge_no_new_frame", cnt, 0);
        rd(2'd1, v);
        chk("edge_status_ovr", v, 32'h2);
        wr(2'd1, 32'h0);

        // Divisor clamp: 0 and 1 become 2, 0xFF frame in 20 (or 22) clocks.
        wr(2'd2, 32'd0);
        send_frame(8'hFF, 2, 1'b0, -1, 8'h00, st);
        wr(2'd2, 32'd1);
        send_frame(8'hFF, 2, 1'b0, -1, 8'h00, st);

`ifdef UART_TX_PARITY_EN
        wr(2'd2, 32'h0001_0004);
        send_frame(8'h07, 4, 1'b1, -1, 8'h00, st);
        wr(2'd2, 32'h0000_0004);
        send_frame(8'h07, 4, 1'b0, -1, 8'h00, st);
`endif

        // Reset at clock 15 of a divisor-4 frame.
        wr(2'd2, 32'd4);
        @(negedge clk);
        in_write_en = 1'b1;
        in_address  = 32'd0;
        in_data     = 32'h5A;
        @(posedge clk); #1;
        in_write_en = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("pre_reset_busy", {31'd0, out_busy}, 32'h1);
        rst = 1'b1;
        in_address = 32'd1;
        #1;
        chk("async_reset_tx", {31'd0, out_tx}, 32'h1);
        chk("async_reset_status", out_read_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd(2'd2, v);
        chk("post_reset_div", v, 32'h1458);
        wr(2'd2, 32'd4);
        send_frame(8'hC9, 4, 1'b0, -1, 8'h00, st);
        chk("post_reset_clean_status", st, 32'h1);

        // Randomized frames against the bit-list model.
        for (int t = 0; t < 8; t++) begin
            int   raw;
            int   eff;
            logic odd;
            logic [7:0] b;
            raw = int'($urandom_range(0, 6));
            odd = 1'($urandom_range(0, 1));
            b   = 8'($urandom_range(0, 255));
            eff = (raw < 2) ? 2 : raw;
            wr(2'd2, {15'd0, odd, 16'(raw)});
            send_frame(b, eff, odd, -1, 8'h00, st);
            chk("rand_status_mid", st, 32'h1);
            rd(2'd0, v);
            chk("rand_txdata_rd", v, {24'd0, b});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the peripheral port of the memory controller; consumes its translated word address, write data and one write-enable bit.
- Returns register contents on one of the controller's read-data inputs.
- Lets the single-cycle core print bytes with ordinary sw/lw instructions.
- Frame format: 8N1, LSB first; bit period set by a programmable divisor.

Parameters:
- DIV_RESET, 16'd5208, divisor reset value in clocks per bit (50 MHz / 9600 baud).
- DIV_W, 16, width of the divisor register and the bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_write_en  in  1  write strobe from the controller's write-enable bit for this peripheral.
- in_address  in  32  word address from the controller; only [1:0] decoded.
- in_data  in  32  store data.
- out_read_data  out  32  register read data for the controller's read mux; combinational from in_address.
- out_tx  out  1  serial line, idles high.
- out_busy  out  1  high while a frame is in flight.

Behaviour:
- Register map by in_address[1:0]:
  - 0 TXDATA: write [7:0] starts a frame; reads {24'b0, last byte written}.
  - 1 STATUS: read {30'b0, overrun, busy}; any write clears overrun.
  - 2 DIVISOR: read/write [DIV_W-1:0]; values below 2 are stored as 2.
  - 3: reads 0, writes ignored.
- Reset values:
  - out_tx=1, out_busy=0, overrun=0, txdata=0, divisor=DIV_RESET.
  - State IDLE, bit counter 0, bit index 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on TXDATA write, latch byte into shift register, go START, out_busy=1 on the next edge.
  - START: out_tx=0 for one bit period.
  - DATA: out_tx=shift[0] for one bit period per bit; shift right; after bit index 7 go STOP.
  - STOP: out_tx=1 for one bit period, then IDLE with out_busy=0.
- Bit timing:
  - Counter loads divisor-1 on each state/bit entry and decrements each clock; bit ends when it reaches 0.
  - One bit period = divisor clocks exactly. Frame = 10*divisor clocks from the first START cycle.
- out_tx is registered, so the line falls on the edge after the write.
- TXDATA write while busy: byte dropped, frame continues unchanged, overrun set (sticky).
- TXDATA write in the same cycle the FSM returns from STOP to IDLE counts as busy: it is dropped and sets overrun.
- DIVISOR write mid-frame takes effect from the next bit period; the current bit is not disturbed.
- Simultaneous STATUS write (clear) and overrun event cannot occur, since only one address is written per cycle.
- Reset mid-frame: line returns high immediately (async), frame is abandoned, no partial resume.
- No read side effects; the core may poll STATUS every cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds PARITY state between DATA and STOP, driving even parity of the byte; frame = 11*divisor.
  - DIVISOR register bit 16 (read/write, reset 0) selects odd parity when 1.
- Undefined: 8N1 only; bit 16 of DIVISOR reads 0 and is not stored.

Decomposition:
- Shared package: state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4); register offsets (REG_TXDATA=0, REG_STATUS=1, REG_DIVISOR=2); STATUS bit positions.
- One sub-module is natural: uart_baud_counter (load value, reload strobe, tick output), reusable for a future RX block.
- The register file and FSM stay in the top.

Test Plan:
- Reset, then read all 4 offsets -> 0x0, 0x0, 0x1458, 0x0; out_tx=1, out_busy=0.
- Write DIVISOR=4, write TXDATA=0x55 -> out_tx sequence 0,1,0,1,0,1,0,1,0,1, each held 4 clocks; out_busy high for exactly 40 clocks.
- DIVISOR=4, write 0xA3, then write 0x41 at clock 10 -> line carries 0xA3 only; STATUS reads 0x3 during the frame and 0x2 after; write STATUS -> reads 0x0.
- DIVISOR write of 0 and of 1 -> DIVISOR reads 2; a frame of 0xFF lasts 20 clocks.
- Assert rst at clock 15 of a DIVISOR=4 frame -> out_tx=1 immediately; next TXDATA write starts a clean frame with no overrun.
- With UART_TX_PARITY_EN: DIVISOR=0x10004, send 0x07 -> parity bit 0 (odd), 11-bit frame of 44 clocks; with bit 16 clear -> parity bit 1.
